// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule controller: streams round keys 0..10 through a valid/ready port.
// Define KEY_SCHED_CACHE_EN to add an 11-entry round-key cache with a random-access read port.
module key_sched_ctrl (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] key_in,
    input  logic         key_vld,
    output logic         key_rdy,
    input  logic         abort,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         rk_vld,
    input  logic         rk_rdy,
    output logic         busy
`ifdef KEY_SCHED_CACHE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         cache_vld
`endif
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t       state;
    logic [127:0] kreg;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [127:0] knext;
    logic         key_hs;
    logic         rk_hs;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box built from its definition: GF(2^8) inverse (x^254, 0 maps to 0) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, t;
        w0  = k[127:96];
        w1  = k[95:64];
        w2  = k[63:32];
        w3  = k[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rc, 24'h000000};
        w0  = w0 ^ t;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign knext = expand(kreg, rcon);

    assign key_rdy  = (state == IDLE) && !abort && !RST;
    assign rk_vld   = (state == EMIT);
    assign busy     = (state == EMIT);
    assign rk_out   = kreg;
    assign rk_round = round;
    assign rk_last  = (state == EMIT) && (round == 4'd10);

    assign key_hs = key_vld && key_rdy;
    assign rk_hs  = rk_vld && rk_rdy && !abort && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            kreg  <= '0;
            round <= '0;
            rcon  <= 8'h01;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (key_vld) begin
                        kreg  <= key_in;
                        round <= '0;
                        rcon  <= 8'h01;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_rdy) begin
                        if (round == 4'd10) begin
                            state <= IDLE;
                        end else begin
                            kreg  <= knext;
                            rcon  <= xtime(rcon);
                            round <= round + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_SCHED_CACHE_EN
    logic [127:0] cache [0:10];

    always_ff @(posedge CLK) begin
        if (RST) begin
            cache_vld <= 1'b0;
            for (int unsigned i = 0; i < 11; i++) cache[i] <= '0;
        end else if (abort || key_hs) begin
            cache_vld <= 1'b0;
        end else if (rk_hs) begin
            cache[round] <= kreg;
            if (round == 4'd10) cache_vld <= 1'b1;
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_idx <= 4'd10) rd_key = cache[rd_idx];
    end
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Scoreboard bench for key_sched_ctrl; exercises the cache port when KEY_SCHED_CACHE_EN is defined.
module tb_key_sched_ctrl;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_vld = 1'b0;
    logic         key_rdy;
    logic         abort = 1'b0;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         rk_vld;
    logic         rk_rdy = 1'b0;
    logic         busy;
`ifdef KEY_SCHED_CACHE_EN
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key;
    logic         cache_vld;
`endif

    key_sched_ctrl dut (
        .CLK(CLK), .RST(RST), .key_in(key_in), .key_vld(key_vld), .key_rdy(key_rdy),
        .abort(abort), .rk_out(rk_out), .rk_round(rk_round), .rk_last(rk_last),
        .rk_vld(rk_vld), .rk_rdy(rk_rdy), .busy(busy)
`ifdef KEY_SCHED_CACHE_EN
        , .rd_idx(rd_idx), .rd_key(rd_key), .cache_vld(cache_vld)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         known;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // FIPS-197 Appendix A.1 expansion of 2b7e1516... as round keys 0..10
    logic [127:0] fips [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    logic [127:0] key2    = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] key2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_fips();
        for (int r = 0; r <= 10; r++) sb.push_back('{rnd: 4'(r), key: fips[r], known: 1'b1});
    endtask

    task automatic push_key2();
        sb.push_back('{rnd: 4'd0, key: key2, known: 1'b1});
        for (int r = 1; r <= 9; r++) sb.push_back('{rnd: 4'(r), key: '0, known: 1'b0});
        sb.push_back('{rnd: 4'd10, key: key2_10, known: 1'b1});
    endtask

    task automatic test_reset();
        key_vld = 1'b1;
        key_in  = fips[0];
        step();
        step();
        total++;
        if ({rk_vld, rk_last, busy, key_rdy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got vld/last/busy/key_rdy=%b want 0000", {rk_vld, rk_last, busy, key_rdy});
        end
        total++;
        if (rk_out !== '0 || rk_round !== 4'd0) begin
            bad++;
            $display("FAIL reset_data: got rk_out=%h rk_round=%0d want 0/0", rk_out, rk_round);
        end
        RST     = 1'b0;
        key_vld = 1'b0;
        step();
        total++;
        if (key_rdy !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got key_rdy=%b busy=%b want 1/0", key_rdy, busy);
        end
    endtask

    task automatic test_full_rate();
        exp_t e;
        key_in  = fips[0];
        key_vld = 1'b1;
        rk_rdy  = 1'b1;
        total++;
        if (key_rdy !== 1'b1) begin
            bad++;
            $display("FAIL fr_key_rdy: got %b want 1", key_rdy);
        end
        push_fips();
        step();
        key_vld = 1'b0;
        for (int c = 0; c < 11; c++) begin
            total++;
            if (rk_vld !== 1'b1 || sb.size() == 0) begin
                bad++;
                $display("FAIL fr_valid cycle %0d: got rk_vld=%b want 1", c, rk_vld);
            end else begin
                e = sb.pop_front();
                total++;
                if (rk_out !== e.key || rk_round !== e.rnd) begin
                    bad++;
                    $display("FAIL fr_key round %0d: got %h/%0d want %h/%0d", c, rk_out, rk_round, e.key, e.rnd);
                end
                total++;
                if (rk_last !== (e.rnd == 4'd10)) begin
                    bad++;
                    $display("FAIL fr_last round %0d: got %b want %b", c, rk_last, e.rnd == 4'd10);
                end
            end
            step();
        end
        total++;
        if (rk_vld !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fr_done: got rk_vld=%b busy=%b want 0/0", rk_vld, busy);
        end
    endtask

`ifdef KEY_SCHED_CACHE_EN
    task automatic test_cache();
        rd_idx = 4'd10;
        #1;
        total++;
        if (rd_key !== fips[10]) begin
            bad++;
            $display("FAIL cache_rd10: got %h want %h", rd_key, fips[10]);
        end
        rd_idx = 4'd0;
        #1;
        total++;
        if (rd_key !== fips[0]) begin
            bad++;
            $display("FAIL cache_rd0: got %h want %h", rd_key, fips[0]);
        end
        rd_idx = 4'd5;
        #1;
        total++;
        if (rd_key !== fips[5]) begin
            bad++;
            $display("FAIL cache_rd5: got %h want %h", rd_key, fips[5]);
        end
        rd_idx = 4'd12;
        #1;
        total++;
        if (rd_key !== '0) begin
            bad++;
            $display("FAIL cache_rd12: got %h want 0", rd_key);
        end
        total++;
        if (cache_vld !== 1'b1) begin
            bad++;
            $display("FAIL cache_vld_set: got %b want 1", cache_vld);
        end
        key_in  = key2;
        key_vld = 1'b1;
        rk_rdy  = 1'b0;
        step();
        key_vld = 1'b0;
        total++;
        if (cache_vld !== 1'b0) begin
            bad++;
            $display("FAIL cache_vld_clear: got %b want 0", cache_vld);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
    endtask
`endif

    task automatic test_stall();
        exp_t e;
        int   cycles = 0;
        int   stalls = 0;
        key_in  = fips[0];
        key_vld = 1'b1;
        rk_rdy  = 1'b0;
        push_fips();
        step();
        key_vld = 1'b0;
        while (sb.size() > 0 && cycles < 300) begin
            rk_rdy = 1'($urandom_range(0, 1));
            #1;
            if (rk_vld) begin
                e = sb[0];
                total++;
                if (rk_out !== e.key || rk_round !== e.rnd || rk_last !== (e.rnd == 4'd10)) begin
                    bad++;
                    $display("FAIL stall_key: got %h/%0d/%b want %h/%0d/%b",
                             rk_out, rk_round, rk_last, e.key, e.rnd, e.rnd == 4'd10);
                end
                if (rk_rdy) void'(sb.pop_front());
                else stalls++;
            end
            step();
            cycles++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL stall_timeout: got %0d keys left want 0", sb.size());
            sb.delete();
        end
        total++;
        if (rk_vld !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_done: got rk_vld=%b busy=%b want 0/0 (stalls=%0d)", rk_vld, busy, stalls);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   cycles = 0;
        key_in  = fips[0];
        key_vld = 1'b1;
        rk_rdy  = 1'b1;
        push_fips();
        step();
        key_vld = 1'b0;
        while (rk_vld && rk_round != 4'd5 && cycles < 20) begin
            void'(sb.pop_front());
            step();
            cycles++;
        end
        total++;
        if (rk_vld !== 1'b1 || rk_round !== 4'd5 || rk_out !== fips[5]) begin
            bad++;
            $display("FAIL abort_at5: got vld=%b round=%0d key=%h want 1/5/%h", rk_vld, rk_round, rk_out, fips[5]);
        end
        abort   = 1'b1;
        key_vld = 1'b1;
        key_in  = key2;
        #1;
        total++;
        if (key_rdy !== 1'b0) begin
            bad++;
            $display("FAIL abort_key_rdy: got %b want 0", key_rdy);
        end
        step();
        abort   = 1'b0;
        key_vld = 1'b0;
        sb.delete();
        total++;
        if (rk_vld !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_next: got rk_vld=%b busy=%b want 0/0", rk_vld, busy);
        end
        key_vld = 1'b1;
        #1;
        total++;
        if (key_rdy !== 1'b1) begin
            bad++;
            $display("FAIL abort_reaccept: got key_rdy=%b want 1", key_rdy);
        end
        push_key2();
        step();
        key_vld = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (rk_vld !== 1'b1 || sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL key2_valid cycle %0d: got rk_vld=%b want 1", c, rk_vld);
            end else begin
                e = sb.pop_front();
                total++;
                if (rk_round !== e.rnd || (e.known && rk_out !== e.key)) begin
                    bad++;
                    $display("FAIL key2_key: got %h/%0d want %h/%0d", rk_out, rk_round, e.key, e.rnd);
                end
            end
            step();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL key2_done: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int cycles = 0;
        key_in  = fips[0];
        key_vld = 1'b1;
        rk_rdy  = 1'b1;
        step();
        key_vld = 1'b0;
        while (rk_round != 4'd3 && cycles < 20) begin
            step();
            cycles++;
        end
        total++;
        if (rk_round !== 4'd3 || rk_out !== fips[3]) begin
            bad++;
            $display("FAIL rmid_at3: got %h/%0d want %h/3", rk_out, rk_round, fips[3]);
        end
        RST = 1'b1;
        step();
        total++;
        if ({rk_vld, rk_last, busy, key_rdy} !== 4'b0000 || rk_out !== '0 || rk_round !== 4'd0) begin
            bad++;
            $display("FAIL rmid_outputs: got flags=%b key=%h round=%0d want 0000/0/0",
                     {rk_vld, rk_last, busy, key_rdy}, rk_out, rk_round);
        end
        RST     = 1'b0;
        key_in  = key2;
        key_vld = 1'b1;
        abort   = 1'b1;
        #1;
        total++;
        if (key_rdy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_abort_rdy: got %b want 0", key_rdy);
        end
        step();
        total++;
        if (busy !== 1'b0 || rk_vld !== 1'b0) begin
            bad++;
            $display("FAIL rmid_abort_block: got busy=%b rk_vld=%b want 0/0", busy, rk_vld);
        end
        abort = 1'b0;
        step();
        key_vld = 1'b0;
        total++;
        if (rk_vld !== 1'b1 || rk_out !== key2 || rk_round !== 4'd0) begin
            bad++;
            $display("FAIL rmid_accept: got %b/%h/%0d want 1/%h/0", rk_vld, rk_out, rk_round, key2);
        end
        for (int c = 0; c < 11; c++) step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_drain: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_rate();
`ifdef KEY_SCHED_CACHE_EN
        test_cache();
`endif
        test_stall();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
